sysram_arbiter: RTL
===================

# sysram_arbiter

Two-port arbiter and sequencer for the single-port, synchronous-read system RAM (ROM 15'h0000–15'h0FFF, RAM 15'h1000–15'h7FFF). It shares the memory between the video fetch unit (real-time, high priority) and the CPU. It issues one access per cycle, tags every in-flight read so data returns to its owner, and blocks CPU writes into the ROM window. It sits between both requesters and the memory's Add/In_Data/Out_Data/we port.

## Interface
- ADDR_W, 15, address width
- DATA_W, 8, data width
- ROM_TOP, 15'h1000, first writable address; writes below it are blocked
- STARVE_MAX, 4, consecutive lost arbitrations before the CPU is forced through (1–15; used only with the guard)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Vid_Req  in  1  video read request; held with Vid_Add until Vid_Ack
- Vid_Add  in  ADDR_W  video read address
- Vid_Ack  out  1  request accepted this cycle (combinational)
- Vid_Data  out  DATA_W  returned read data
- Vid_Valid  out  1  one-cycle pulse; Vid_Data valid
- Cpu_Req  in  1  CPU request; held with Cpu_We/Cpu_Add/Cpu_Wdata until Cpu_Ack
- Cpu_We  in  1  1 = write, 0 = read
- Cpu_Add  in  ADDR_W  CPU address
- Cpu_Wdata  in  DATA_W  CPU write data
- Cpu_Ack  out  1  request accepted this cycle (combinational)
- Cpu_Rdata  out  DATA_W  returned read data
- Cpu_Valid  out  1  one-cycle pulse; Cpu_Rdata valid (reads only)
- Wr_Fault  out  1  one-cycle pulse; CPU write to address < ROM_TOP was dropped
- Mem_Add  out  ADDR_W  to memory Add
- Mem_In_Data  out  DATA_W  to memory In_Data
- Mem_we  out  1  to memory we
- Mem_Out_Data  in  DATA_W  from memory Out_Data

## Operation
- Arbitration (cycle A), one winner per cycle:
  - Video wins whenever Vid_Req=1, unless the starvation guard forces the CPU.
  - Otherwise the CPU wins if Cpu_Req=1.
  - The winner's Ack is high in cycle A. The loser's Ack stays low, and the loser keeps its request stable.
- Issue register (edge ending A), capturing from the winner:
  - Mem_Add ← winner's address.
  - Mem_In_Data ← Cpu_Wdata (CPU) or hold (video).
  - Mem_we ← Cpu_We & (Cpu_Add >= ROM_TOP) for the CPU; 0 for video.
  - Tag stage 1 ← {valid, owner, is_read}. Any accepted access counts as a read except a CPU write.
- With no winner: Mem_we ← 0, Mem_Add/Mem_In_Data hold, tag valid ← 0.
- Blocked write (CPU, Cpu_We=1, Cpu_Add < ROM_TOP): still acked, Mem_we stays 0, Wr_Fault=1 in cycle A+1, no Valid. Mem_Add still updates; the memory performs a harmless read.
- Return path:
  - Tag shifts stage 1 → stage 2 at the edge ending A+1, which is when the memory samples its address.
  - Mem_Out_Data is valid in A+2. At the edge ending A+2 it is registered into Vid_Data or Cpu_Rdata, selected by the stage-2 owner.
  - Matching Valid is high in A+3 only if stage-2 valid & is_read.
  - The other requester's data register holds.
- Fully pipelined: back-to-back grants each cycle, returns in grant order, no bubbles.

## Timing
- Ack: same cycle as Req (combinational on Req, the guard state and the other Req).
- Read latency: Ack in cycle A → Valid in cycle A+3.
- Write: Mem_we=1 during A+1 only.
- Mem_we: never 1 for video or for Add < ROM_TOP.
- Reset values: Mem_Add=0, Mem_In_Data=0, Mem_we=0, Vid_Data=0, Cpu_Rdata=0, Vid_Valid=0, Cpu_Valid=0, Wr_Fault=0, tags invalid, starve counter=0.
- Vid_Ack/Cpu_Ack are combinational, so they are low while rst_n=0.
- Reset mid-operation:
  - In-flight accesses are discarded and no Valid is emitted for them.
  - Mem_we drops immediately (asynchronous).
  - First grant is possible in the first cycle after rst_n rises.
- Simultaneous Vid_Req and Cpu_Req: video is acked; the CPU waits (subject to the guard).
- Requester dropping Req before Ack: permitted, nothing is issued.

## Configuration
- Macro SYSRAM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter increments each cycle in which Cpu_Req=1 and the CPU loses to video.
  - When it equals STARVE_MAX, the CPU wins the next cycle where Cpu_Req=1, even with Vid_Req=1.
  - The counter clears on any Cpu_Ack, and whenever Cpu_Req=0.
- Undefined: strict video priority. The counter is not built, and the CPU can be starved indefinitely.

## Test plan
- Reset, then Vid_Req with Vid_Add=15'h0900 one cycle, memory model returning 8'hA5 → Vid_Ack same cycle; Mem_Add=15'h0900 next cycle; Vid_Valid=1 with Vid_Data=8'hA5 exactly 3 cycles after Ack; Cpu_Valid stays 0.
- CPU write Cpu_Add=15'h1234, Cpu_Wdata=8'h5A → Cpu_Ack; next cycle Mem_we=1, Mem_Add=15'h1234, Mem_In_Data=8'h5A; no Cpu_Valid. CPU read of 15'h1234 then gets Cpu_Rdata=8'h5A.
- CPU write to 15'h0100 → Cpu_Ack=1; Mem_we stays 0 all cycles; Wr_Fault pulses one cycle, 1 cycle after Ack; ROM contents unchanged.
- Alternating video/CPU reads to 15'h1000..15'h1003 on consecutive cycles → four Acks in four cycles; four Valids in consecutive cycles, each on the correct owner with the correct data.
- Vid_Req held high for 10 cycles, Cpu_Req high throughout, STARVE_MAX=4:
  - With the guard: Cpu_Ack in cycle 5 (after 4 video grants), video resumes in cycle 6.
  - Without the guard: no Cpu_Ack until Vid_Req falls.
- Assert rst_n=0 one cycle after a read Ack → Mem_we=0 and no Valid ever appears for that read; after release, a new read completes normally with latency 3.

Source files
------------

// File: rtl/sysram_arbiter.sv
// sysram_arbiter
//   Shares the single-port, synchronous-read system RAM between the video
//   fetch unit (high priority) and the CPU. One access is issued per cycle;
//   every issued access carries a tag {vld, owner, rd} down a two-stage
//   pipeline so read data is returned to the requester that asked for it.
//   CPU writes below ROM_TOP are acknowledged but dropped (Wr_Fault pulse).
//
//   Optional feature: define SYSRAM_ARB_STARVE_GUARD_EN to build the CPU
//   starvation guard (forces one CPU grant after STARVE_MAX lost cycles).
//   Without it, video has strict priority.
//
//   Ports
//     clk, rst_n                 clock, async active-low reset
//     Vid_Req/Vid_Add            video read request (held until Vid_Ack)
//     Vid_Ack                    video accepted this cycle (combinational)
//     Vid_Data/Vid_Valid         video read return (Valid = 1-cycle pulse)
//     Cpu_Req/We/Add/Wdata       CPU request (held until Cpu_Ack)
//     Cpu_Ack                    CPU accepted this cycle (combinational)
//     Cpu_Rdata/Cpu_Valid        CPU read return (reads only)
//     Wr_Fault                   pulse: CPU write into ROM window dropped
//     Mem_Add/Mem_In_Data/Mem_we to memory, registered
//     Mem_Out_Data               from memory, valid two cycles after issue

module sysram_arbiter #(
  parameter int unsigned             ADDR_W     = 15,
  parameter int unsigned             DATA_W     = 8,
  parameter logic [ADDR_W-1:0]       ROM_TOP    = 15'h1000,
  parameter int unsigned             STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Vid_Req,
  input  logic [ADDR_W-1:0] Vid_Add,
  output logic              Vid_Ack,
  output logic [DATA_W-1:0] Vid_Data,
  output logic              Vid_Valid,
  input  logic              Cpu_Req,
  input  logic              Cpu_We,
  input  logic [ADDR_W-1:0] Cpu_Add,
  input  logic [DATA_W-1:0] Cpu_Wdata,
  output logic              Cpu_Ack,
  output logic [DATA_W-1:0] Cpu_Rdata,
  output logic              Cpu_Valid,
  output logic              Wr_Fault,
  output logic [ADDR_W-1:0] Mem_Add,
  output logic [DATA_W-1:0] Mem_In_Data,
  output logic              Mem_we,
  input  logic [DATA_W-1:0] Mem_Out_Data
);

  localparam logic OWN_VID = 1'b0;
  localparam logic OWN_CPU = 1'b1;

  typedef struct packed {
    logic vld;
    logic owner;
    logic rd;
  } tag_t;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic force_cpu;
  logic vid_win, cpu_win;
  logic cpu_wr_ok, cpu_wr_blk;

  always_comb begin
    vid_win    = Vid_Req & ~force_cpu;
    cpu_win    = Cpu_Req & ~vid_win;
    cpu_wr_ok  = Cpu_We & (Cpu_Add >= ROM_TOP);
    cpu_wr_blk = Cpu_We & (Cpu_Add <  ROM_TOP);
  end

  // Acks are qualified by rst_n so nothing is accepted while in reset.
  assign Vid_Ack = rst_n & vid_win;
  assign Cpu_Ack = rst_n & cpu_win;

`ifdef SYSRAM_ARB_STARVE_GUARD_EN
  // Counts consecutive cycles the CPU asked and lost to video.
  logic [3:0] starve_q, starve_d;

  always_comb begin
    force_cpu = Cpu_Req & (starve_q == STARVE_MAX[3:0]);
    starve_d  = starve_q;
    if (!Cpu_Req || cpu_win)
      starve_d = 4'd0;
    else if (vid_win)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= 4'd0;
    else        starve_q <= starve_d;
  end
`else
  logic [3:0] unused_starve_max;
  assign unused_starve_max = STARVE_MAX[3:0];
  assign force_cpu         = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Issue register + tag pipeline
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] mem_add_q, mem_add_d;
  logic [DATA_W-1:0] mem_in_q,  mem_in_d;
  logic              mem_we_q,  mem_we_d;
  logic              fault_q,   fault_d;
  tag_t              tag1_q,    tag1_d;
  tag_t              tag2_q,    tag2_d;

  always_comb begin
    mem_add_d = mem_add_q;
    mem_in_d  = mem_in_q;
    mem_we_d  = 1'b0;
    fault_d   = 1'b0;
    tag1_d    = '0;
    if (vid_win) begin
      mem_add_d = Vid_Add;
      tag1_d    = '{vld: 1'b1, owner: OWN_VID, rd: 1'b1};
    end else if (cpu_win) begin
      // A blocked write still moves Mem_Add; the memory does a harmless read.
      mem_add_d = Cpu_Add;
      mem_in_d  = Cpu_Wdata;
      mem_we_d  = cpu_wr_ok;
      fault_d   = cpu_wr_blk;
      tag1_d    = '{vld: 1'b1, owner: OWN_CPU, rd: ~Cpu_We};
    end
    // Stage 2 lines up with the edge where the memory samples the address.
    tag2_d = tag1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_add_q <= '0;
      mem_in_q  <= '0;
      mem_we_q  <= 1'b0;
      fault_q   <= 1'b0;
      tag1_q    <= '0;
      tag2_q    <= '0;
    end else begin
      mem_add_q <= mem_add_d;
      mem_in_q  <= mem_in_d;
      mem_we_q  <= mem_we_d;
      fault_q   <= fault_d;
      tag1_q    <= tag1_d;
      tag2_q    <= tag2_d;
    end
  end

  // ---------------------------------------------------------------------
  // Return path: Mem_Out_Data is valid while the stage-2 tag is present.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] vid_data_q,  vid_data_d;
  logic [DATA_W-1:0] cpu_data_q,  cpu_data_d;
  logic              vid_valid_q, vid_valid_d;
  logic              cpu_valid_q, cpu_valid_d;

  always_comb begin
    vid_valid_d = tag2_q.vld & tag2_q.rd & (tag2_q.owner == OWN_VID);
    cpu_valid_d = tag2_q.vld & tag2_q.rd & (tag2_q.owner == OWN_CPU);
    vid_data_d  = vid_data_q;
    cpu_data_d  = cpu_data_q;
    if (vid_valid_d) vid_data_d = Mem_Out_Data;
    if (cpu_valid_d) cpu_data_d = Mem_Out_Data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_data_q  <= '0;
      cpu_data_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_valid_q <= 1'b0;
    end else begin
      vid_data_q  <= vid_data_d;
      cpu_data_q  <= cpu_data_d;
      vid_valid_q <= vid_valid_d;
      cpu_valid_q <= cpu_valid_d;
    end
  end

  assign Mem_Add     = mem_add_q;
  assign Mem_In_Data = mem_in_q;
  assign Mem_we      = mem_we_q;
  assign Wr_Fault    = fault_q;
  assign Vid_Data    = vid_data_q;
  assign Vid_Valid   = vid_valid_q;
  assign Cpu_Rdata   = cpu_data_q;
  assign Cpu_Valid   = cpu_valid_q;

endmodule
